// File: rtl/mac_pkg.sv
// Shared types and width helpers for the vector multiply-accumulate datapath.
package mac_pkg;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_flags_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width that holds the sum of all lane products without overflow.
    function automatic int sum_wid(input int data_wid, input int lanes);
        return 2 * data_wid + clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One lane multiplier: registered operands, then a registered product.
// Two register stages match the input/output registers of a DSP slice.
module mac_lane_mult
    import mac_pkg::*;
#(
    parameter int DATA_WID = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  signed_mode_i,
    input  logic [DATA_WID-1:0]   a_i,
    input  logic [DATA_WID-1:0]   b_i,
    output logic [2*DATA_WID:0]   prod_o
);

    localparam int EXT_WID  = DATA_WID + 1;
    localparam int FULL_WID = 2 * DATA_WID + 2;

    logic                       ext_en_s;
    logic signed [EXT_WID-1:0]  a_d, b_d;
    logic signed [EXT_WID-1:0]  a_q, b_q;
    logic signed [FULL_WID-1:0] a_full_s, b_full_s, full_s;
    logic [2*DATA_WID:0]        prod_q;

    always_comb begin
        ext_en_s = 1'b0;
        case (signed_mode_i)
            MODE_SIGNED:   ext_en_s = 1'b1;
            MODE_UNSIGNED: ext_en_s = 1'b0;
            default:       ext_en_s = 1'b0;
        endcase
        a_d = {ext_en_s & a_i[DATA_WID-1], a_i};
        b_d = {ext_en_s & b_i[DATA_WID-1], b_i};
    end

    assign a_full_s = {{(FULL_WID-EXT_WID){a_q[EXT_WID-1]}}, a_q};
    assign b_full_s = {{(FULL_WID-EXT_WID){b_q[EXT_WID-1]}}, b_q};
    assign full_s   = a_full_s * b_full_s;

    // The product always fits in 2*DATA_WID+1 bits, so the top bit is dropped.
    always_ff @(posedge clock) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
        end else if (en_i) begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= full_s[2*DATA_WID:0];
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/vec_mac_unit.sv
// Pipelined vector dot-product engine: LANES multipliers, lane reduction,
// frame accumulator with optional saturation, valid/ready on both sides.
module vec_mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_WID = 16,
    parameter int LANES    = 4,
    parameter int ACC_WID  = 40,
    parameter int SAT      = 1
) (
    input  logic                         clock,
    input  logic                         rst,
    input  logic                         signed_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_first,
    input  logic                         in_last,
    input  logic [LANES*DATA_WID-1:0]    a_vec,
    input  logic [LANES*DATA_WID-1:0]    b_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WID-1:0]           out_acc,
    output logic                         out_sat
);

    localparam int PROD_WID = 2 * DATA_WID + 1;
    localparam int SUM_WID  = sum_wid(DATA_WID, LANES);
    localparam int NXT_WID  = ((ACC_WID > SUM_WID) ? ACC_WID : SUM_WID) + 1;
    localparam logic signed [NXT_WID-1:0] ACC_MAX =
        $signed({{(NXT_WID-ACC_WID+1){1'b0}}, {(ACC_WID-1){1'b1}}});
    localparam logic signed [NXT_WID-1:0] ACC_MIN =
        $signed({{(NXT_WID-ACC_WID+1){1'b1}}, {(ACC_WID-1){1'b0}}});

    logic                              en_s;
    beat_flags_t                       f0_q, f1_q, f2_q;
    logic [LANES-1:0][PROD_WID-1:0]    prod_s;
    logic signed [SUM_WID-1:0]         sum_d, sum_q;
    logic signed [NXT_WID-1:0]         base_s, nxt_s;
    logic [ACC_WID-1:0]                acc_d, acc_q;
    logic                              sticky_d, sticky_q, sat_ev_s;
    logic                              out_valid_q;
    logic [ACC_WID-1:0]                out_acc_q;
    logic                              out_sat_q;

    assign en_s     = !(out_valid_q && !out_ready);
    assign in_ready = en_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mac_lane_mult #(
            .DATA_WID (DATA_WID)
        ) u_mult (
            .clock         (clock),
            .rst           (rst),
            .en_i          (en_s),
            .signed_mode_i (signed_mode),
            .a_i           (a_vec[g*DATA_WID +: DATA_WID]),
            .b_i           (b_vec[g*DATA_WID +: DATA_WID]),
            .prod_o        (prod_s[g])
        );
    end

    // Reduce lane products into one sign-extended beat sum.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_WID'($signed(prod_s[i]));
        end
    end

    // Accumulate with one guard bit, then clamp or wrap into ACC_WID.
    always_comb begin
        if (f2_q.first) begin
            base_s = '0;
        end else begin
            base_s = NXT_WID'($signed(acc_q));
        end
        nxt_s    = base_s + NXT_WID'(sum_q);
        sat_ev_s = 1'b0;
        acc_d    = nxt_s[ACC_WID-1:0];
        if ((SAT != 0) && (nxt_s > ACC_MAX)) begin
            acc_d    = ACC_MAX[ACC_WID-1:0];
            sat_ev_s = 1'b1;
        end else if ((SAT != 0) && (nxt_s < ACC_MIN)) begin
            acc_d    = ACC_MIN[ACC_WID-1:0];
            sat_ev_s = 1'b1;
        end else begin
            acc_d    = nxt_s[ACC_WID-1:0];
            sat_ev_s = 1'b0;
        end
        sticky_d = (f2_q.first ? 1'b0 : sticky_q) | sat_ev_s;
    end

    // Flag pipeline, beat sum and accumulator, all frozen while stalled.
    always_ff @(posedge clock) begin
        if (rst) begin
            f0_q     <= '0;
            f1_q     <= '0;
            f2_q     <= '0;
            sum_q    <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else if (en_s) begin
            f0_q     <= '{valid: in_valid, first: in_first, last: in_last};
            f1_q     <= f0_q;
            f2_q     <= f1_q;
            sum_q    <= sum_d;
            if (f2_q.valid) begin
                acc_q    <= acc_d;
                sticky_q <= sticky_d;
            end
        end
    end

    // Result register: a new last beat may reload in the same cycle as a pop.
    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
        end else if (en_s && f2_q.valid && f2_q.last) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= acc_d;
            out_sat_q   <= sticky_d;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_sat   = out_sat_q;

endmodule
